// File: rtl/can_fd_rx_fifo.sv
// Frame-oriented CAN-FD receive FIFO: word data RAM plus a per-frame length/overrun
// record RAM, with commit, abort rollback, random-access head-frame reads and release.
module can_fd_rx_fifo #(
   parameter  int DATA_W      = 32,
   parameter  int DEPTH       = 128,
   parameter  int INFO_DEPTH  = 32,
   parameter  int MAX_FRAME_W = 18,
   parameter  int AFULL_THR   = 96,
   localparam int AW          = $clog2(DEPTH),
   localparam int IW          = $clog2(INFO_DEPTH),
   localparam int LW          = $clog2(MAX_FRAME_W + 1),
   localparam int OW          = $clog2(MAX_FRAME_W)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              reset_mode,
   input  logic              wr,
   input  logic [DATA_W-1:0] data_in,
   input  logic              wr_commit,
   input  logic              wr_abort,
   input  logic              release_buffer,
   input  logic [OW-1:0]     addr,
   output logic [DATA_W-1:0] data_out,
   output logic [LW-1:0]     head_len,
   output logic              head_overrun,
   output logic [IW:0]       info_cnt,
   output logic [AW:0]       fifo_cnt,
   output logic              info_empty,
   output logic              afull,
   output logic              overrun_evt
);

   logic [DATA_W-1:0] mem      [DEPTH];
   logic [LW:0]       info_mem [INFO_DEPTH];

   logic [AW-1:0] rd_ptr, wr_ptr, frm_start, wr_ptr_nx;
   logic [IW-1:0] rd_info, wr_info;
   logic [LW-1:0] len_cnt, len_final;
   logic          ovr_latch, ovr_final;
   logic [LW:0]   head_rec;
   logic          full, info_full, rel_ok, wr_ok;
   logic          commit, commit_ok, commit_drop, rollback;

   always_comb begin
      full         = (fifo_cnt == (AW+1)'(DEPTH));
      info_full    = (info_cnt == (IW+1)'(INFO_DEPTH));
      info_empty   = (info_cnt == '0);
      afull        = (fifo_cnt >= (AW+1)'(AFULL_THR));
      head_rec     = info_mem[rd_info];
      head_len     = info_empty ? '0 : head_rec[LW:1];
      head_overrun = !info_empty && head_rec[0];
      data_out     = mem[rd_ptr + AW'(addr)];

      rel_ok    = release_buffer && !info_empty;
      wr_ok     = wr && !wr_abort && !full && (len_cnt < LW'(MAX_FRAME_W));
      ovr_final = ovr_latch | (wr & ~wr_ok);
      len_final = len_cnt + LW'(wr_ok);
      // info-full is sampled before this cycle's release, so a concurrent release frees the slot
      commit      = wr_commit && !wr_abort && ((len_final != '0) || ovr_final);
      commit_ok   = commit && (!info_full || rel_ok);
      commit_drop = commit && info_full && !rel_ok;
      rollback    = wr_abort || commit_drop;
      wr_ptr_nx   = rollback ? frm_start : wr_ptr + AW'(wr_ok);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         frm_start   <= '0;
         rd_info     <= '0;
         wr_info     <= '0;
         len_cnt     <= '0;
         ovr_latch   <= 1'b0;
         fifo_cnt    <= '0;
         info_cnt    <= '0;
         overrun_evt <= 1'b0;
      end else if (reset_mode) begin
         wr_ptr      <= rd_ptr;
         frm_start   <= rd_ptr;
         wr_info     <= rd_info;
         len_cnt     <= '0;
         ovr_latch   <= 1'b0;
         fifo_cnt    <= '0;
         info_cnt    <= '0;
         overrun_evt <= 1'b0;
      end else begin
         wr_ptr <= wr_ptr_nx;
         if (commit_ok) begin
            frm_start <= wr_ptr_nx;
            wr_info   <= wr_info + 1'b1;
         end
         if (rel_ok) begin
            rd_ptr  <= rd_ptr + AW'(head_len);
            rd_info <= rd_info + 1'b1;
         end
         info_cnt <= info_cnt + (IW+1)'(commit_ok) - (IW+1)'(rel_ok);
         fifo_cnt <= fifo_cnt + (AW+1)'(wr_ok)
                     - (rel_ok   ? (AW+1)'(head_len)  : '0)
                     - (rollback ? (AW+1)'(len_final) : '0);
         len_cnt     <= (rollback || wr_commit) ? '0 : len_final;
         ovr_latch   <= (wr_abort || wr_commit) ? 1'b0 : ovr_final;
         overrun_evt <= (commit_ok && ovr_final) || commit_drop;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_ok && !reset_mode)
         mem[wr_ptr] <= data_in;
      if (commit_ok && !reset_mode)
         info_mem[wr_info] <= {len_final, ovr_final};
   end

endmodule
